// File: rtl/jtag_ir_dr.sv
// rtl/jtag_ir_dr.sv - JTAG instruction/data register block with FIR coefficient write port
//
// Purpose:
//   Implements the JTAG instruction register and three data registers
//   (IDCODE, BYPASS, COEF). The TAP controller lives outside; this block
//   only sees its decoded state. A COEF data scan ends in a one-tck write
//   strobe to the FIR coefficient bank.
//
// Ports:
//   tck        test clock, all state updates on its rising edge
//   por        asynchronous active-high reset
//   state      TAP controller state (4-bit encoding)
//   tdi        serial test data in
//   tdo        serial test data out (combinational)
//   tdo_en     high while tdo carries shift data
//   ir         current (updated) instruction
//   coef_addr  FIR coefficient write address
//   coef_data  FIR coefficient write data
//   coef_we    one-tck write strobe
module jtag_ir_dr #(
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5001,
    parameter int          COEF_AW    = 4,
    parameter int          COEF_DW    = 16
) (
    input  logic               tck,
    input  logic               por,
    input  logic [3:0]         state,
    input  logic               tdi,
    output logic               tdo,
    output logic               tdo_en,
    output logic [3:0]         ir,
    output logic [COEF_AW-1:0] coef_addr,
    output logic [COEF_DW-1:0] coef_data,
    output logic               coef_we
);

    localparam int COEF_W = COEF_AW + COEF_DW;

    // TAP state encodings
    localparam logic [3:0] ST_TLR    = 4'hF;
    localparam logic [3:0] ST_RTI    = 4'hC;
    localparam logic [3:0] ST_SEL_DR = 4'h7;
    localparam logic [3:0] ST_CAP_DR = 4'h6;
    localparam logic [3:0] ST_SH_DR  = 4'h2;
    localparam logic [3:0] ST_EX1_DR = 4'h1;
    localparam logic [3:0] ST_PAU_DR = 4'h3;
    localparam logic [3:0] ST_EX2_DR = 4'h0;
    localparam logic [3:0] ST_UPD_DR = 4'h5;
    localparam logic [3:0] ST_SEL_IR = 4'h4;
    localparam logic [3:0] ST_CAP_IR = 4'hE;
    localparam logic [3:0] ST_SH_IR  = 4'hA;
    localparam logic [3:0] ST_EX1_IR = 4'h9;
    localparam logic [3:0] ST_PAU_IR = 4'hB;
    localparam logic [3:0] ST_EX2_IR = 4'h8;
    localparam logic [3:0] ST_UPD_IR = 4'hD;

    // Instruction codes
    localparam logic [3:0] INS_IDCODE = 4'h1;
    localparam logic [3:0] INS_COEF   = 4'h8;
    localparam logic [3:0] INS_BYPASS = 4'hF;

    // Fixed pattern captured into the IR shift register; the trailing 01
    // lets a board-level scan find the IR boundary.
    localparam logic [3:0] IR_CAPTURE = 4'b0101;

    logic [3:0]         ir_q,        ir_d;
    logic [3:0]         ir_sr_q,     ir_sr_d;
    logic [31:0]        id_sr_q,     id_sr_d;
    logic               byp_q,       byp_d;
    logic [COEF_W-1:0]  coef_sr_q,   coef_sr_d;
    logic [COEF_AW-1:0] coef_addr_q, coef_addr_d;
    logic [COEF_DW-1:0] coef_data_q, coef_data_d;
    logic               coef_we_q,   coef_we_d;

    logic sel_id;
    logic sel_coef;
    logic sel_byp;

    // DR selection follows the updated instruction. Unknown codes fall
    // through to BYPASS, so only IDCODE and COEF need explicit decodes.
    always_comb begin
        sel_id   = (ir_q == INS_IDCODE);
        sel_coef = (ir_q == INS_COEF);
        sel_byp  = !sel_id && !sel_coef;
    end

    // Instruction path. In TLR the instruction is forced to IDCODE every
    // edge while the IR shift register keeps whatever it held.
    always_comb begin
        ir_d    = ir_q;
        ir_sr_d = ir_sr_q;
        case (state)
            ST_TLR:    ir_d    = INS_IDCODE;
            ST_CAP_IR: ir_sr_d = IR_CAPTURE;
            ST_SH_IR:  ir_sr_d = {tdi, ir_sr_q[3:1]};
            ST_UPD_IR: ir_d    = ir_sr_q;
            default:   ;
        endcase
    end

    // Data register path. Only the selected DR captures or shifts; all
    // others hold, and pause/exit states hold everything.
    always_comb begin
        id_sr_d   = id_sr_q;
        byp_d     = byp_q;
        coef_sr_d = coef_sr_q;
        case (state)
            ST_CAP_DR: begin
                if (sel_id)   id_sr_d   = IDCODE_VAL;
                if (sel_coef) coef_sr_d = {coef_addr_q, coef_data_q};
                if (sel_byp)  byp_d     = 1'b0;
            end
            ST_SH_DR: begin
                if (sel_id)   id_sr_d   = {tdi, id_sr_q[31:1]};
                if (sel_coef) coef_sr_d = {tdi, coef_sr_q[COEF_W-1:1]};
                if (sel_byp)  byp_d     = tdi;
            end
            default: ;
        endcase
    end

    // Coefficient write port. The strobe is registered so it is high for
    // the single tck cycle following the UPD_DR edge.
    always_comb begin
        coef_addr_d = coef_addr_q;
        coef_data_d = coef_data_q;
        coef_we_d   = 1'b0;
        if (state == ST_UPD_DR && sel_coef) begin
            coef_addr_d = coef_sr_q[COEF_W-1:COEF_DW];
            coef_data_d = coef_sr_q[COEF_DW-1:0];
            coef_we_d   = 1'b1;
        end
    end

    // tdo is combinational so the first bit of a shift is presented while
    // the TAP sits in the shift state, before the first shift edge.
    always_comb begin
        tdo    = 1'b0;
        tdo_en = 1'b0;
        if (state == ST_SH_IR) begin
            tdo    = ir_sr_q[0];
            tdo_en = 1'b1;
        end else if (state == ST_SH_DR) begin
            tdo_en = 1'b1;
            if (sel_id)        tdo = id_sr_q[0];
            else if (sel_coef) tdo = coef_sr_q[0];
            else               tdo = byp_q;
        end
    end

    always_ff @(posedge tck or posedge por) begin
        if (por) begin
            ir_q        <= INS_IDCODE;
            ir_sr_q     <= IR_CAPTURE;
            id_sr_q     <= '0;
            byp_q       <= 1'b0;
            coef_sr_q   <= '0;
            coef_addr_q <= '0;
            coef_data_q <= '0;
            coef_we_q   <= 1'b0;
        end else begin
            ir_q        <= ir_d;
            ir_sr_q     <= ir_sr_d;
            id_sr_q     <= id_sr_d;
            byp_q       <= byp_d;
            coef_sr_q   <= coef_sr_d;
            coef_addr_q <= coef_addr_d;
            coef_data_q <= coef_data_d;
            coef_we_q   <= coef_we_d;
        end
    end

    assign ir        = ir_q;
    assign coef_addr = coef_addr_q;
    assign coef_data = coef_data_q;
    assign coef_we   = coef_we_q;

endmodule

// File: tb/tb_jtag_ir_dr.sv
// tb/tb_jtag_ir_dr.sv - self-checking bench for jtag_ir_dr
module tb_jtag_ir_dr;

    localparam logic [31:0] IDV = 32'h1234_5001;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int CW = AW + DW;

    localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SEL_DR = 4'h7, S_CAP_DR = 4'h6;
    localparam logic [3:0] S_SH_DR = 4'h2, S_EX1_DR = 4'h1, S_PAU_DR = 4'h3, S_EX2_DR = 4'h0;
    localparam logic [3:0] S_UPD_DR = 4'h5, S_SEL_IR = 4'h4, S_CAP_IR = 4'hE, S_SH_IR = 4'hA;
    localparam logic [3:0] S_EX1_IR = 4'h9, S_PAU_IR = 4'hB, S_EX2_IR = 4'h8, S_UPD_IR = 4'hD;

    logic          tck = 1'b0;
    logic          por = 1'b1;
    logic [3:0]    state = S_TLR;
    logic          tdi = 1'b0;
    logic          tdo;
    logic          tdo_en;
    logic [3:0]    ir;
    logic [AW-1:0] coef_addr;
    logic [DW-1:0] coef_data;
    logic          coef_we;

    jtag_ir_dr #(.IDCODE_VAL(IDV), .COEF_AW(AW), .COEF_DW(DW)) dut (
        .tck(tck), .por(por), .state(state), .tdi(tdi),
        .tdo(tdo), .tdo_en(tdo_en), .ir(ir),
        .coef_addr(coef_addr), .coef_data(coef_data), .coef_we(coef_we)
    );

    always #5 tck = ~tck;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    logic last_tdo;
    logic last_en;

    // Reference model: every register is a queue of bits, front = next bit out.
    typedef bit bq_t[$];
    bq_t m_irq, m_id, m_byp, m_coef;
    logic [3:0]    m_ir;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_we;

    function automatic bq_t mkq(input logic [31:0] v, input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(v[i]);
        return q;
    endfunction

    function automatic logic [31:0] qval(input bq_t q);
        logic [31:0] v = '0;
        for (int i = 0; i < q.size(); i++) v[i] = q[i];
        return v;
    endfunction

    // 0 = IDCODE, 1 = COEF, 2 = BYPASS
    function automatic int msel(input logic [3:0] i);
        if (i == 4'h1) return 0;
        if (i == 4'h8) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_ir   = 4'h1;
        m_irq  = mkq(32'h5, 4);
        m_id   = mkq(32'h0, 32);
        m_byp  = mkq(32'h0, 1);
        m_coef = mkq(32'h0, CW);
        m_addr = '0;
        m_data = '0;
        m_we   = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] st, input bit d);
        int s;
        logic [31:0] v;
        s = msel(m_ir);
        m_we = 1'b0;
        if (st == S_TLR) m_ir = 4'h1;
        else if (st == S_CAP_IR) m_irq = mkq(32'h5, 4);
        else if (st == S_SH_IR) begin void'(m_irq.pop_front()); m_irq.push_back(d); end
        else if (st == S_UPD_IR) m_ir = qval(m_irq)[3:0];
        else if (st == S_CAP_DR) begin
            if (s == 0) m_id = mkq(IDV, 32);
            else if (s == 1) m_coef = mkq({12'h0, m_addr, m_data}, CW);
            else m_byp = mkq(32'h0, 1);
        end else if (st == S_SH_DR) begin
            if (s == 0) begin void'(m_id.pop_front()); m_id.push_back(d); end
            else if (s == 1) begin void'(m_coef.pop_front()); m_coef.push_back(d); end
            else begin void'(m_byp.pop_front()); m_byp.push_back(d); end
        end else if (st == S_UPD_DR && s == 1) begin
            v = qval(m_coef);
            m_addr = v[CW-1:DW];
            m_data = v[DW-1:0];
            m_we = 1'b1;
        end
    endtask

    function automatic bit exp_tdo(input logic [3:0] st);
        int s;
        s = msel(m_ir);
        if (st == S_SH_IR) return m_irq[0];
        if (st == S_SH_DR) return (s == 0) ? m_id[0] : (s == 1) ? m_coef[0] : m_byp[0];
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One tck cycle: drive inputs after the falling edge, compare all outputs
    // against the model, then advance the model on the rising edge.
    task automatic cyc(input logic [3:0] st, input bit d, input bit p);
        @(negedge tck);
        state = st;
        tdi   = d;
        por   = p;
        #1;
        if (p) model_reset();
        chk("tdo",       {31'h0, tdo},       {31'h0, exp_tdo(st)});
        chk("tdo_en",    {31'h0, tdo_en},    {31'h0, (st == S_SH_IR || st == S_SH_DR)});
        chk("ir",        {28'h0, ir},        {28'h0, m_ir});
        chk("coef_addr", {28'h0, coef_addr}, {28'h0, m_addr});
        chk("coef_data", {16'h0, coef_data}, {16'h0, m_data});
        chk("coef_we",   {31'h0, coef_we},   {31'h0, m_we});
        if (coef_we === 1'b1) we_cnt++;
        last_tdo = tdo;
        last_en  = tdo_en;
        @(posedge tck);
        if (!p) model_edge(st, d);
    endtask

    task automatic ir_scan(input logic [3:0] v, output logic [3:0] seen);
        cyc(S_RTI, 0, 0);
        cyc(S_SEL_DR, 0, 0);
        cyc(S_SEL_IR, 0, 0);
        cyc(S_CAP_IR, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(S_SH_IR, v[i], 0);
            seen[i] = last_tdo;
        end
        cyc(S_EX1_IR, 0, 0);
        cyc(S_UPD_IR, 0, 0);
        cyc(S_RTI, 0, 0);
    endtask

    task automatic dr_scan(input logic [31:0] v, input int n, output logic [31:0] seen, output int ens);
        seen = '0;
        ens  = 0;
        cyc(S_RTI, 0, 0);
        cyc(S_SEL_DR, 0, 0);
        cyc(S_CAP_DR, 0, 0);
        for (int i = 0; i < n; i++) begin
            cyc(S_SH_DR, v[i], 0);
            seen[i] = last_tdo;
            if (last_en) ens++;
        end
        cyc(S_EX1_DR, 0, 0);
        cyc(S_UPD_DR, 0, 0);
        cyc(S_RTI, 0, 0);
    endtask

    function automatic logic [3:0] tap_next(input logic [3:0] s, input bit tms);
        case (s)
            S_TLR:    return tms ? S_TLR    : S_RTI;
            S_RTI:    return tms ? S_SEL_DR : S_RTI;
            S_SEL_DR: return tms ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: return tms ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  return tms ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: return tms ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: return tms ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: return tms ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: return tms ? S_SEL_DR : S_RTI;
            S_SEL_IR: return tms ? S_TLR    : S_CAP_IR;
            S_CAP_IR: return tms ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  return tms ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: return tms ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: return tms ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: return tms ? S_UPD_IR : S_SH_IR;
            default:  return tms ? S_SEL_DR : S_RTI;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  s4;
        logic [31:0] seen;
        int          ens;
        logic [3:0]  st;
        logic [19:0] pv;

        model_reset();

        // Reset state
        cyc(S_TLR, 0, 1);
        cyc(S_TLR, 0, 1);
        chk("rst_ir", {28'h0, ir}, 32'h1);
        chk("rst_we", {31'h0, coef_we}, 32'h0);
        chk("rst_tdo_en", {31'h0, tdo_en}, 32'h0);

        // IDCODE read after reset release
        cyc(S_TLR, 0, 0);
        dr_scan(32'h0, 32, seen, ens);
        chk("idcode_seq", seen, 32'h1234_5001);
        chk("idcode_en", ens, 32);
        chk("idcode_no_we", we_cnt, 0);

        // IR scan of COEF
        ir_scan(4'h8, s4);
        chk("ir_capture_seq", {28'h0, s4}, 32'h5);
        chk("ir_coef", {28'h0, ir}, 32'h8);

        // Coefficient write
        we_cnt = 0;
        dr_scan({12'h0, 4'h3, 16'hA5C3}, 20, seen, ens);
        cyc(S_RTI, 0, 0);
        cyc(S_RTI, 0, 0);
        chk("coef_addr_wr", {28'h0, coef_addr}, 32'h3);
        chk("coef_data_wr", {16'h0, coef_data}, 32'hA5C3);
        chk("coef_we_once", we_cnt, 1);

        // Readback shifts the same value back in so the rewrite is harmless
        dr_scan({12'h0, 4'h3, 16'hA5C3}, 20, seen, ens);
        chk("coef_readback", seen, {12'h0, 4'h3, 16'hA5C3});

        // Unknown instruction behaves as BYPASS
        ir_scan(4'h6, s4);
        chk("ir_unknown", {28'h0, ir}, 32'h6);
        we_cnt = 0;
        dr_scan(32'hB, 4, seen, ens);
        chk("bypass_seq", seen, 32'h6);
        chk("bypass_no_we", we_cnt, 0);

        // Paused COEF shift
        ir_scan(4'h8, s4);
        pv = {4'hC, 16'h1F2E};
        cyc(S_SEL_DR, 0, 0);
        cyc(S_CAP_DR, 0, 0);
        for (int i = 0; i < 10; i++) cyc(S_SH_DR, pv[i], 0);
        cyc(S_EX1_DR, 0, 0);
        for (int i = 0; i < 3; i++) cyc(S_PAU_DR, 1, 0);
        cyc(S_EX2_DR, 0, 0);
        for (int i = 10; i < 20; i++) cyc(S_SH_DR, pv[i], 0);
        cyc(S_UPD_DR, 0, 0);
        cyc(S_RTI, 0, 0);
        chk("pause_addr", {28'h0, coef_addr}, 32'hC);
        chk("pause_data", {16'h0, coef_data}, 32'h1F2E);

        // por mid COEF scan, held across an UPD_DR edge
        we_cnt = 0;
        cyc(S_SEL_DR, 0, 0);
        cyc(S_CAP_DR, 0, 0);
        for (int i = 0; i < 7; i++) cyc(S_SH_DR, 1, 0);
        cyc(S_SH_DR, 1, 1);
        cyc(S_UPD_DR, 0, 1);
        chk("por_ir", {28'h0, ir}, 32'h1);
        chk("por_addr", {28'h0, coef_addr}, 32'h0);
        chk("por_data", {16'h0, coef_data}, 32'h0);
        cyc(S_RTI, 0, 0);
        chk("por_no_we", we_cnt, 0);

        // TLR restores IDCODE on the next edge
        ir_scan(4'hF, s4);
        chk("ir_bypass", {28'h0, ir}, 32'hF);
        cyc(S_TLR, 0, 0);
        cyc(S_RTI, 0, 0);
        chk("tlr_ir", {28'h0, ir}, 32'h1);

        // Random TAP walk with random tdi and occasional por
        st = S_RTI;
        for (int n = 0; n < 4000; n++) begin
            bit tms, d, p;
            tms = ($urandom_range(0, 3) == 0);
            d   = $urandom_range(0, 1) == 1;
            p   = ($urandom_range(0, 399) == 0);
            cyc(st, d, p);
            st = tap_next(st, tms);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
